// File: rtl/svo_pattern_stream.sv
// svo_pattern_stream -- test-pattern video source, one active frame at a time,
// presented as a valid/ready pixel stream with a start-of-frame flag.
//
// Ports:
//   clk              pixel clock
//   resetn           asynchronous active-low reset (pixel domain, synchronised)
//   pattern_sel[1:0] 0 colour bars, 1 checkerboard, 2 gradient, 3 frame-count solid
//   out_axis_tvalid  pixel valid (high from first edge after reset, never drops)
//   out_axis_tready  sink ready
//   out_axis_tdata   {R,G,B} for the current (x,y)
//   out_axis_tuser   high on pixel (0,0)
//   frame_count      completed frames, modulo 2^16
//
// Optional feature macro: SVO_PATTERN_OVERLAY_EN -- bouncing 64x64 white box
// overlaid on every pattern (needs H_ACTIVE >= 64 and V_ACTIVE >= 64).
//
// Outputs are registered: the next (x,y) state is computed combinationally and
// the pixel for it is registered on the same edge, so tdata/tuser always
// describe the registered (x,y).

module svo_pattern_stream #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  pattern_sel,
    output logic        out_axis_tvalid,
    input  logic        out_axis_tready,
    output logic [23:0] out_axis_tdata,
    output logic        out_axis_tuser,
    output logic [15:0] frame_count
);

    // Bar width; constant, so no hardware divider.
    localparam int SEG = H_ACTIVE / 8;

    logic [11:0] x, y, bar_cnt;
    logic [2:0]  bar;
    logic [1:0]  pat;

    logic [11:0] nx, ny, nbar_cnt;
    logic [2:0]  nbar;
    logic [1:0]  npat;
    logic [15:0] nfc;
    logic [23:0] npix;
    logic        last_x, last_y;

    function automatic logic [23:0] pattern_pix(
        input logic [1:0]  p,
        input logic [11:0] px,
        input logic [11:0] py,
        input logic [2:0]  b,
        input logic [7:0]  fc
    );
        logic [23:0] r;
        r = 24'h000000;
        case (p)
            2'd0: begin
                case (b)
                    3'd0: r = 24'hFFFFFF;
                    3'd1: r = 24'hFFFF00;
                    3'd2: r = 24'h00FFFF;
                    3'd3: r = 24'h00FF00;
                    3'd4: r = 24'hFF00FF;
                    3'd5: r = 24'hFF0000;
                    3'd6: r = 24'h0000FF;
                    default: r = 24'h000000;
                endcase
            end
            2'd1: r = (px[5] ^ py[5]) ? 24'hFFFFFF : 24'h000000;
            2'd2: r = {px[7:0], py[7:0], px[7:0] ^ py[7:0]};
            default: r = {fc, 8'h80, ~fc};
        endcase
        return r;
    endfunction

`ifdef SVO_PATTERN_OVERLAY_EN
    localparam logic [11:0] BX_MAX = 12'(H_ACTIVE - 64);
    localparam logic [11:0] BY_MAX = 12'(V_ACTIVE - 64);

    logic [11:0] bx, by, nbx, nby;
    logic        bx_up, by_up, nbx_up, nby_up;
    logic        in_box;
`endif

    assign last_x = (x == 12'(H_ACTIVE - 1));
    assign last_y = (y == 12'(V_ACTIVE - 1));

    always_comb begin
        nx       = x;
        ny       = y;
        nbar     = bar;
        nbar_cnt = bar_cnt;
        npat     = pat;
        nfc      = frame_count;
`ifdef SVO_PATTERN_OVERLAY_EN
        nbx      = bx;
        nby      = by;
        nbx_up   = bx_up;
        nby_up   = by_up;
`endif
        if (!out_axis_tvalid) begin
            // First edge out of reset: present (0,0) and latch the pattern.
            nx       = '0;
            ny       = '0;
            nbar     = '0;
            nbar_cnt = '0;
            npat     = pattern_sel;
        end else if (out_axis_tready) begin
            if (last_x) begin
                nx       = '0;
                nbar     = '0;
                nbar_cnt = '0;
                if (last_y) begin
                    ny   = '0;
                    nfc  = frame_count + 16'd1;
                    // Only ever re-latched at a frame boundary.
                    npat = pattern_sel;
`ifdef SVO_PATTERN_OVERLAY_EN
                    nbx = bx_up ? bx + 12'd1 : bx - 12'd1;
                    nby = by_up ? by + 12'd1 : by - 12'd1;
                    if (nbx == BX_MAX || nbx == 12'd0) nbx_up = ~bx_up;
                    if (nby == BY_MAX || nby == 12'd0) nby_up = ~by_up;
`endif
                end else begin
                    ny = y + 12'd1;
                end
            end else begin
                nx = x + 12'd1;
                if (bar_cnt == 12'(SEG - 1)) begin
                    nbar_cnt = '0;
                    nbar     = bar + 3'd1;
                end else begin
                    nbar_cnt = bar_cnt + 12'd1;
                end
            end
        end

        npix = pattern_pix(npat, nx, ny, nbar, nfc[7:0]);
`ifdef SVO_PATTERN_OVERLAY_EN
        in_box = ({1'b0, nx} >= {1'b0, nbx}) && ({1'b0, nx} < {1'b0, nbx} + 13'd64) &&
                 ({1'b0, ny} >= {1'b0, nby}) && ({1'b0, ny} < {1'b0, nby} + 13'd64);
        if (in_box) npix = 24'hFFFFFF;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_axis_tvalid <= 1'b0;
            out_axis_tdata  <= '0;
            out_axis_tuser  <= 1'b0;
            frame_count     <= '0;
            x               <= '0;
            y               <= '0;
            bar             <= '0;
            bar_cnt         <= '0;
            pat             <= '0;
`ifdef SVO_PATTERN_OVERLAY_EN
            bx              <= '0;
            by              <= '0;
            bx_up           <= 1'b1;
            by_up           <= 1'b1;
`endif
        end else begin
            out_axis_tvalid <= 1'b1;
            out_axis_tdata  <= npix;
            out_axis_tuser  <= (nx == 12'd0) && (ny == 12'd0);
            frame_count     <= nfc;
            x               <= nx;
            y               <= ny;
            bar             <= nbar;
            bar_cnt         <= nbar_cnt;
            pat             <= npat;
`ifdef SVO_PATTERN_OVERLAY_EN
            bx              <= nbx;
            by              <= nby;
            bx_up           <= nbx_up;
            by_up           <= nby_up;
`endif
        end
    end

endmodule

// File: tb/tb_svo_pattern_stream.sv
module tb_svo_pattern_stream;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int FR = H * V;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        out_axis_tvalid;
    logic        out_axis_tready = 1'b0;
    logic [23:0] out_axis_tdata;
    logic        out_axis_tuser;
    logic [15:0] frame_count;

    svo_pattern_stream #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .pattern_sel     (pattern_sel),
        .out_axis_tvalid (out_axis_tvalid),
        .out_axis_tready (out_axis_tready),
        .out_axis_tdata  (out_axis_tdata),
        .out_axis_tuser  (out_axis_tuser),
        .frame_count     (frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: number of completed transfers since reset, plus the
    // pattern latched for each frame number.
    bit mvalid = 0;
    int n = 0;
    int fpat[int];
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] exp_pix(input int idx);
        int px, py, f, p;
        logic [7:0] xb, yb, fb;
        px = idx % H;
        py = (idx / H) % V;
        f  = idx / FR;
        p  = fpat.exists(f) ? fpat[f] : 0;
        xb = px[7:0];
        yb = py[7:0];
        fb = f[7:0];
        case (p)
            0: return bars[px / (H / 8)];
            1: return (((px >> 5) ^ (py >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
            2: return {xb, yb, xb ^ yb};
            default: return {fb, 8'h80, ~fb};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (transfer %0d)", name, act, exp, n);
        end
    endtask

    task automatic compare_model();
        int f;
        f = n / FR;
        check("tvalid", {31'd0, out_axis_tvalid}, 32'd1);
        check("tdata", {8'd0, out_axis_tdata}, {8'd0, exp_pix(n)});
        check("tuser", {31'd0, out_axis_tuser}, {31'd0, (n % FR) == 0});
        check("frame_count", {16'd0, frame_count}, {16'd0, f[15:0]});
    endtask

    task automatic step(input logic rdy, input logic [1:0] sel);
        bit xfer;
        @(negedge clk);
        out_axis_tready = rdy;
        pattern_sel = sel;
        xfer = mvalid && rdy;
        @(posedge clk);
        if (!mvalid) begin
            mvalid = 1;
            n = 0;
            fpat[0] = sel;
        end else if (xfer) begin
            n++;
            if (n % FR == 0) fpat[n / FR] = sel;
        end
        #1;
        compare_model();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tvalid"}, {31'd0, out_axis_tvalid}, 32'd0);
        check({tag, "_tdata"}, {8'd0, out_axis_tdata}, 32'd0);
        check({tag, "_tuser"}, {31'd0, out_axis_tuser}, 32'd0);
        check({tag, "_fc"}, {16'd0, frame_count}, 32'd0);
    endtask

    task automatic do_reset(input logic [1:0] sel);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_zero("rst_async");
        mvalid = 0;
        n = 0;
        fpat.delete();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hold");
        @(negedge clk);
        resetn = 1'b1;
        pattern_sel = sel;
        out_axis_tready = 1'b1;   // tvalid is still low, so no transfer here
        @(posedge clk);
        mvalid = 1;
        n = 0;
        fpat[0] = sel;
        #1;
        compare_model();
    endtask

    task automatic advance(input int target, input logic [1:0] sel);
        int k = 0;
        while ((n % FR) != target && k < 300) begin
            step(1'b1, sel);
            k++;
        end
        check("advance_bound", n % FR, target);
    endtask

    typedef struct {
        logic        rdy;
        logic [23:0] d;
        logic        u;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [23:0] hold_d;
        logic        hold_u;
        int k;

        // First line of colour bars after reset (pixels 1..16), one stall.
        tbl[0]  = '{1'b1, 24'hFFFFFF, 1'b0};
        tbl[1]  = '{1'b1, 24'hFFFF00, 1'b0};
        tbl[2]  = '{1'b1, 24'hFFFF00, 1'b0};
        tbl[3]  = '{1'b0, 24'hFFFF00, 1'b0};
        tbl[4]  = '{1'b1, 24'h00FFFF, 1'b0};
        tbl[5]  = '{1'b1, 24'h00FFFF, 1'b0};
        tbl[6]  = '{1'b1, 24'h00FF00, 1'b0};
        tbl[7]  = '{1'b1, 24'h00FF00, 1'b0};
        tbl[8]  = '{1'b1, 24'hFF00FF, 1'b0};
        tbl[9]  = '{1'b1, 24'hFF00FF, 1'b0};
        tbl[10] = '{1'b1, 24'hFF0000, 1'b0};
        tbl[11] = '{1'b1, 24'hFF0000, 1'b0};
        tbl[12] = '{1'b1, 24'h0000FF, 1'b0};
        tbl[13] = '{1'b1, 24'h0000FF, 1'b0};
        tbl[14] = '{1'b1, 24'h000000, 1'b0};
        tbl[15] = '{1'b1, 24'h000000, 1'b0};
        tbl[16] = '{1'b1, 24'hFFFFFF, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");

        // Release with colour bars
        do_reset(2'd0);
        check("first_tdata", {8'd0, out_axis_tdata}, 32'h00FFFFFF);
        check("first_tuser", {31'd0, out_axis_tuser}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rdy, 2'd0);
            check($sformatf("tbl%0d_tdata", i), {8'd0, out_axis_tdata}, {8'd0, tbl[i].d});
            check($sformatf("tbl%0d_tuser", i), {31'd0, out_axis_tuser}, {31'd0, tbl[i].u});
        end

        // Three complete frames
        k = 0;
        while (n < 192 && k < 400) begin
            step(1'b1, 2'd0);
            k++;
        end
        check("fc_after_192", {16'd0, frame_count}, 32'd3);
        check("tuser_at_192", {31'd0, out_axis_tuser}, 32'd1);

        // Backpressure at (3,1)
        advance(19, 2'd0);
        hold_d = out_axis_tdata;
        hold_u = out_axis_tuser;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'd0);
            check("bp_hold_tdata", {8'd0, out_axis_tdata}, {8'd0, hold_d});
            check("bp_hold_tuser", {31'd0, out_axis_tuser}, {31'd0, hold_u});
        end
        step(1'b1, 2'd0);

        // Switch to gradient mid-frame at (5,2); takes effect next frame only
        advance(37, 2'd0);
        step(1'b1, 2'd2);
        check("latch_midframe_bars", {8'd0, out_axis_tdata}, {8'd0, bars[(38 % H) / 2]});
        advance(17, 2'd2);
        check("latch_next_frame_px11", {8'd0, out_axis_tdata}, 32'h00010100);

        // Solid colour from frame counter
        do_reset(2'd3);
        check("solid_f0", {8'd0, out_axis_tdata}, 32'h000080FF);
        step(1'b1, 2'd3);
        advance(0, 2'd3);
        check("solid_f1", {8'd0, out_axis_tdata}, 32'h000180FE);

        // Random ready / pattern select, with one mid-frame reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset(2'($urandom_range(0, 3)));
            else step(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/svo_pattern_stream.md
# svo_pattern_stream

Test-pattern video source that generates one active-video frame at a time as a valid/ready pixel stream with a start-of-frame flag. It sits directly upstream of `svo_hdmi`, which consumes the stream, inserts blanking and TMDS-encodes it. It runs in the pixel clock domain and is reset by the synchronised pixel-domain reset.

## Interface
Parameters:
- `H_ACTIVE`, 1280: active pixels per line; multiple of 8, range 16–4095.
- `V_ACTIVE`, 720: active lines per frame; range 4–4095.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `resetn`  in  1  reset; asynchronous assert, active low.
- `pattern_sel`  in  2  pattern select: 0 colour bars, 1 checkerboard, 2 gradient, 3 frame-count solid colour.
- `out_axis_tvalid`  out  1  pixel valid.
- `out_axis_tready`  in  1  sink ready.
- `out_axis_tdata`  out  24  pixel, laid out as {R[23:16], G[15:8], B[7:0]}.
- `out_axis_tuser`  out  1  high on pixel (0,0) of each frame.
- `frame_count`  out  16  completed frames; wraps modulo 2^16.

## Operation
- Internal state:
  - pixel counters `x` (0..H_ACTIVE-1) and `y` (0..V_ACTIVE-1);
  - bar index `bar` (0..7) with a sub-counter that advances `bar` every H_ACTIVE/8 pixels. No divider is used.
  - latched pattern register `pat`.
- Output register stage: `tdata`/`tuser` always describe the pixel at the current (`x`,`y`).
- Transfer occurs when `out_axis_tvalid && out_axis_tready`. On each transfer:
  - `x` increments.
  - At `x == H_ACTIVE-1`: `x` ← 0, `bar` ← 0, and `y` increments.
  - At `y == V_ACTIVE-1` together with `x == H_ACTIVE-1`: `y` ← 0 and `frame_count` increments.
- `pattern_sel` is sampled into `pat` only when the next pixel is (0,0): on reset release and on the last-pixel transfer. A change mid-frame never tears a frame.
- Pattern functions (`fc` = `frame_count[7:0]`):
  - 0, colour bars by `bar`: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 1, checkerboard: `x[5]^y[5]` ? FFFFFF : 000000.
  - 2, gradient: {`x[7:0]`, `y[7:0]`, `x[7:0]^y[7:0]`}.
  - 3, solid colour: {`fc`, 8'h80, ~`fc`}.
- `out_axis_tuser` = (`x`==0 && `y`==0).

## Timing
- Reset (asynchronous, while `resetn`=0):
  - `tvalid`=0, `tdata`=0, `tuser`=0, `frame_count`=0;
  - `x`=`y`=`bar`=0, `pat`=0.
- First rising edge after `resetn` deasserts:
  - `tvalid`→1 with pixel (0,0) and `tuser`=1;
  - `pat` loads `pattern_sel` on the same edge.
- Once high, `tvalid` stays high until the next reset. The source never inserts bubbles.
- Backpressure: while `tready`=0, `tdata`, `tuser` and all counters hold exactly.
- Throughput: with `tready` held at 1, one pixel per clock and H_ACTIVE×V_ACTIVE clocks per frame.
- Latency: the pixel for the new (`x`,`y`) appears on the edge after the transfer, with registered outputs.
- `frame_count` updates on the same edge that presents pixel (0,0) of the next frame.
- Reset asserted mid-frame: all state clears immediately. The next frame starts at (0,0) with `tuser`=1.

## Configuration
- Macro: `SVO_PATTERN_OVERLAY_EN`.
- Defined:
  - A 64×64 white (FFFFFF) box is overlaid on every pattern.
  - Box top-left (`bx`,`by`) resets to (0,0).
  - On each frame wrap, `bx` moves ±1 and `by` moves ±1. Each axis reverses direction on reaching 0 or H_ACTIVE-64 / V_ACTIVE-64.
  - Box is visible where `bx`≤`x`<`bx`+64 and `by`≤`y`<`by`+64.
  - Requires H_ACTIVE≥64 and V_ACTIVE≥64.
- Undefined: no overlay logic or box registers exist; output is the pure pattern.

## Test plan
- Reset: hold `resetn`=0 → `tvalid`=0, `tdata`=0, `tuser`=0, `frame_count`=0. Release with `pattern_sel`=0 → next edge `tvalid`=1, `tuser`=1, `tdata`=FFFFFF.
- Bars: H_ACTIVE=16, V_ACTIVE=4, `tready`=1 → line pixels run in pairs FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; `tuser` is high once per 64 transfers; `frame_count`=3 after 192 transfers.
- Backpressure: drop `tready` for 5 cycles at pixel (3,1) → `tdata`/`tuser` unchanged and no pixel skipped or duplicated against the reference model.
- Pattern latch: switch `pattern_sel` 0→2 at pixel (5,2) → rest of frame stays bars; next frame pixel (1,1) = 010100.
- Solid: `pattern_sel`=3 → frame 0 pixels 0080FF; after first wrap 0180FE.
- Overlay (macro defined, 1280×720): frame 0 pixel (63,63)=FFFFFF and (64,0)=pattern. After 2 frames the box is at (2,2), so pixel (1,1) shows the pattern.
